icw_ocw_sequencer: RTL and testbench

Command sequencer for the 8259 PIC that sits directly behind the read/write bus interface. It consumes qualified write strobes (A0 plus data byte) and walks the ICW1→ICW2→[ICW3]→[ICW4] initialization sequence. After initialization it decodes OCW1/OCW2/OCW3 writes. It holds all configuration registers and issues one-cycle command pulses that the priority resolver, IMR/ISR logic and cascade logic consume.

---
 rtl/icw_ocw_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_icw_ocw_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icw_ocw_sequencer.sv
// 8259 command sequencer: walks ICW1..ICW4 initialization, then decodes OCW1..OCW3
// writes into configuration registers and one-cycle command pulses.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | out of reset, waiting for ICW1; all other writes ignored
// ST_WAIT_ICW2 | ICW1 accepted, next a0=1 write is ICW2 (vector base)
// ST_WAIT_ICW3 | cascaded mode, next a0=1 write is ICW3 (slave mask / ID)
// ST_WAIT_ICW4 | IC4 was set, next a0=1 write is ICW4 (mode bits)
// ST_READY     | initialized; a0=1 -> OCW1, a0=0 -> OCW2 / OCW3
module icw_ocw_sequencer #(
  parameter logic [7:0] IMR_INIT   = 8'h00,
  parameter bit         CASCADE_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_stb,
  input  logic       a0,
  input  logic [7:0] din,
  output logic [4:0] vector_base,
  output logic       ltim,
  output logic       sngl,
  output logic [7:0] cascade_cfg,
  output logic       upm,
  output logic       aeoi,
  output logic       ms,
  output logic       buf_mode,
  output logic       sfnm,
  output logic [7:0] imr,
  output logic       ocw2_stb,
  output logic [2:0] ocw2_cmd,
  output logic [2:0] ocw2_level,
  output logic       read_isr,
  output logic       smm,
  output logic       poll_stb,
  output logic       init_done
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_ICW2 = 3'd1,
    ST_WAIT_ICW3 = 3'd2,
    ST_WAIT_ICW4 = 3'd3,
    ST_READY     = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic       ic4, ic4_nxt;
  logic [4:0] vector_base_nxt;
  logic       ltim_nxt, sngl_nxt;
  logic [7:0] cascade_cfg_nxt;
  logic       upm_nxt, aeoi_nxt, ms_nxt, buf_mode_nxt, sfnm_nxt;
  logic [7:0] imr_nxt;
  logic       ocw2_stb_nxt;
  logic [2:0] ocw2_cmd_nxt, ocw2_level_nxt;
  logic       read_isr_nxt, smm_nxt, poll_stb_nxt;
  logic       is_icw1;

  assign is_icw1   = wr_stb && !a0 && din[4];
  assign init_done = (state == ST_READY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      ic4         <= 1'b0;
      vector_base <= '0;
      ltim        <= 1'b0;
      sngl        <= 1'b0;
      cascade_cfg <= '0;
      upm         <= 1'b0;
      aeoi        <= 1'b0;
      ms          <= 1'b0;
      buf_mode    <= 1'b0;
      sfnm        <= 1'b0;
      imr         <= IMR_INIT;
      ocw2_stb    <= 1'b0;
      ocw2_cmd    <= '0;
      ocw2_level  <= '0;
      read_isr    <= 1'b0;
      smm         <= 1'b0;
      poll_stb    <= 1'b0;
    end else begin
      state       <= state_nxt;
      ic4         <= ic4_nxt;
      vector_base <= vector_base_nxt;
      ltim        <= ltim_nxt;
      sngl        <= sngl_nxt;
      cascade_cfg <= cascade_cfg_nxt;
      upm         <= upm_nxt;
      aeoi        <= aeoi_nxt;
      ms          <= ms_nxt;
      buf_mode    <= buf_mode_nxt;
      sfnm        <= sfnm_nxt;
      imr         <= imr_nxt;
      ocw2_stb    <= ocw2_stb_nxt;
      ocw2_cmd    <= ocw2_cmd_nxt;
      ocw2_level  <= ocw2_level_nxt;
      read_isr    <= read_isr_nxt;
      smm         <= smm_nxt;
      poll_stb    <= poll_stb_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    ic4_nxt         = ic4;
    vector_base_nxt = vector_base;
    ltim_nxt        = ltim;
    sngl_nxt        = sngl;
    cascade_cfg_nxt = cascade_cfg;
    upm_nxt         = upm;
    aeoi_nxt        = aeoi;
    ms_nxt          = ms;
    buf_mode_nxt    = buf_mode;
    sfnm_nxt        = sfnm;
    imr_nxt         = imr;
    ocw2_stb_nxt    = 1'b0;
    ocw2_cmd_nxt    = ocw2_cmd;
    ocw2_level_nxt  = ocw2_level;
    read_isr_nxt    = read_isr;
    smm_nxt         = smm;
    poll_stb_nxt    = 1'b0;

    // ICW1 restarts initialization from any state, overriding every other decode
    if (is_icw1) begin
      ltim_nxt     = din[3];
      sngl_nxt     = din[1];
      ic4_nxt      = din[0];
      imr_nxt      = IMR_INIT;
      smm_nxt      = 1'b0;
      read_isr_nxt = 1'b0;
      upm_nxt      = 1'b0;
      aeoi_nxt     = 1'b0;
      ms_nxt       = 1'b0;
      buf_mode_nxt = 1'b0;
      sfnm_nxt     = 1'b0;
      state_nxt    = ST_WAIT_ICW2;
    end else if (wr_stb) begin
      case (state)
        ST_WAIT_ICW2: begin
          if (a0) begin
            vector_base_nxt = din[7:3];
            if (!sngl && CASCADE_EN) state_nxt = ST_WAIT_ICW3;
            else if (ic4)            state_nxt = ST_WAIT_ICW4;
            else                     state_nxt = ST_READY;
          end
        end
        ST_WAIT_ICW3: begin
          if (a0) begin
            cascade_cfg_nxt = din;
            state_nxt       = ic4 ? ST_WAIT_ICW4 : ST_READY;
          end
        end
        ST_WAIT_ICW4: begin
          if (a0) begin
            upm_nxt      = din[0];
            aeoi_nxt     = din[1];
            ms_nxt       = din[2];
            buf_mode_nxt = din[3];
            sfnm_nxt     = din[4];
            state_nxt    = ST_READY;
          end
        end
        ST_READY: begin
          if (a0) begin
            imr_nxt = din;
          end else if (din[4:3] == 2'b00) begin
            // every OCW2 code is forwarded, including 000, for downstream decode
            ocw2_cmd_nxt   = din[7:5];
            ocw2_level_nxt = din[2:0];
            ocw2_stb_nxt   = 1'b1;
          end else if (din[4:3] == 2'b01) begin
            if (din[6]) smm_nxt      = din[5];
            if (din[1]) read_isr_nxt = din[0];
            if (din[2]) poll_stb_nxt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icw_ocw_sequencer.sv
// Self-checking bench for icw_ocw_sequencer: directed scenarios plus randomized
// traffic against a queue-based model of the pending initialization words.
module tb_icw_ocw_sequencer;

  localparam logic [7:0] IMR_INIT = 8'hC3;
  localparam bit         CASC     = 1'b1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_stb = 1'b0;
  logic       a0 = 1'b0;
  logic [7:0] din = 8'h00;
  logic [4:0] vector_base;
  logic       ltim, sngl;
  logic [7:0] cascade_cfg;
  logic       upm, aeoi, ms, buf_mode, sfnm;
  logic [7:0] imr;
  logic       ocw2_stb;
  logic [2:0] ocw2_cmd, ocw2_level;
  logic       read_isr, smm, poll_stb, init_done;

  icw_ocw_sequencer #(.IMR_INIT(IMR_INIT), .CASCADE_EN(CASC)) dut (
    .clk(clk), .reset(reset), .wr_stb(wr_stb), .a0(a0), .din(din),
    .vector_base(vector_base), .ltim(ltim), .sngl(sngl), .cascade_cfg(cascade_cfg),
    .upm(upm), .aeoi(aeoi), .ms(ms), .buf_mode(buf_mode), .sfnm(sfnm),
    .imr(imr), .ocw2_stb(ocw2_stb), .ocw2_cmd(ocw2_cmd), .ocw2_level(ocw2_level),
    .read_isr(read_isr), .smm(smm), .poll_stb(poll_stb), .init_done(init_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [38:0] dut_vec;
  assign dut_vec = {vector_base, ltim, sngl, cascade_cfg, upm, aeoi, ms, buf_mode, sfnm,
                    imr, ocw2_stb, ocw2_cmd, ocw2_level, read_isr, smm, poll_stb, init_done};

  // Reference model: configuration values plus a queue of still-expected ICW numbers
  logic [4:0] m_vb;
  logic       m_ltim, m_sngl;
  logic [7:0] m_casc;
  logic [4:0] m_icw4;
  logic [7:0] m_imr;
  logic       m_stb, m_poll, m_risr, m_smm, m_started;
  logic [2:0] m_cmd, m_lvl;
  int         pend[$];

  function automatic logic [38:0] model_vec();
    logic rdy;
    rdy = m_started && (pend.size() == 0);
    return {m_vb, m_ltim, m_sngl, m_casc, m_icw4[0], m_icw4[1], m_icw4[2], m_icw4[3],
            m_icw4[4], m_imr, m_stb, m_cmd, m_lvl, m_risr, m_smm, m_poll, rdy};
  endfunction

  task automatic model_reset();
    m_vb = '0; m_ltim = 0; m_sngl = 0; m_casc = '0; m_icw4 = '0; m_imr = IMR_INIT;
    m_stb = 0; m_poll = 0; m_risr = 0; m_smm = 0; m_started = 0;
    m_cmd = '0; m_lvl = '0;
    pend.delete();
  endtask

  task automatic model_write(input logic s, input logic a, input logic [7:0] d);
    int step;
    m_stb = 0;
    m_poll = 0;
    if (s) begin
      if (!a && d[4]) begin
        m_ltim = d[3]; m_sngl = d[1];
        m_imr = IMR_INIT; m_smm = 0; m_risr = 0; m_icw4 = '0;
        pend.delete();
        pend.push_back(2);
        if (!d[1] && CASC) pend.push_back(3);
        if (d[0]) pend.push_back(4);
        m_started = 1;
      end else if (m_started && pend.size() != 0) begin
        if (a) begin
          step = pend.pop_front();
          if (step == 2) m_vb = d[7:3];
          else if (step == 3) m_casc = d;
          else m_icw4 = d[4:0];
        end
      end else if (m_started) begin
        if (a) m_imr = d;
        else if (d[4:3] == 2'b00) begin
          m_cmd = d[7:5]; m_lvl = d[2:0]; m_stb = 1;
        end else begin
          if (d[6]) m_smm = d[5];
          if (d[1]) m_risr = d[0];
          if (d[2]) m_poll = 1;
        end
      end
    end
  endtask

  // One clock cycle: drive at negedge, sample #1 after the rising edge
  task automatic cyc(input logic s, input logic a, input logic [7:0] d);
    @(negedge clk);
    wr_stb = s; a0 = a; din = d;
    @(posedge clk);
    #1;
    if (!reset) model_write(s, a, d);
  endtask

  task automatic do_reset();
    reset = 1;
    cyc(0, 0, 8'h00);
    cyc(0, 0, 8'h00);
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (imr !== IMR_INIT) begin
      failures++; $display("FAIL reset_imr got=%h exp=%h", imr, IMR_INIT);
    end
    checks++;
    if (dut_vec !== {28'h0, IMR_INIT, 11'h0}) begin
      failures++; $display("FAIL reset_outputs got=%h exp=%h", dut_vec, {28'h0, IMR_INIT, 11'h0});
    end
  endtask

  task automatic test_full_init();
    do_reset();
    cyc(1, 0, 8'h11);
    cyc(1, 1, 8'h48);
    cyc(1, 1, 8'h04);
    checks++;
    if (init_done !== 1'b0) begin
      failures++; $display("FAIL full_init_early_done got=%b exp=0", init_done);
    end
    cyc(1, 1, 8'h03);
    checks++;
    if ({init_done, vector_base, cascade_cfg, upm, aeoi, ms, imr} !==
        {1'b1, 5'h09, 8'h04, 1'b1, 1'b1, 1'b0, IMR_INIT}) begin
      failures++;
      $display("FAIL full_init_cfg got done=%b vb=%h casc=%h upm=%b aeoi=%b ms=%b imr=%h exp 1 09 04 1 1 0 %h",
               init_done, vector_base, cascade_cfg, upm, aeoi, ms, imr, IMR_INIT);
    end
    checks++;
    if (dut_vec !== model_vec()) begin
      failures++; $display("FAIL full_init_model got=%h exp=%h", dut_vec, model_vec());
    end
  endtask

  task automatic test_single_no_icw4();
    do_reset();
    cyc(1, 0, 8'h1A);
    cyc(1, 1, 8'h20);
    checks++;
    if ({init_done, vector_base, ltim, sngl, upm, aeoi, ms, buf_mode, sfnm} !==
        {1'b1, 5'h04, 1'b1, 1'b1, 5'b00000}) begin
      failures++;
      $display("FAIL single_init got done=%b vb=%h ltim=%b sngl=%b icw4=%b%b%b%b%b exp 1 04 1 1 00000",
               init_done, vector_base, ltim, sngl, upm, aeoi, ms, buf_mode, sfnm);
    end
    cyc(1, 1, 8'hF0);
    checks++;
    if (imr !== 8'hF0) begin
      failures++; $display("FAIL single_ocw1 got=%h exp=f0", imr);
    end
  endtask

  task automatic test_back_to_back();
    cyc(1, 0, 8'h63);
    checks++;
    if ({ocw2_stb, ocw2_cmd, ocw2_level} !== {1'b1, 3'b011, 3'd3}) begin
      failures++; $display("FAIL ocw2_pulse got stb=%b cmd=%b lvl=%0d exp 1 011 3", ocw2_stb, ocw2_cmd, ocw2_level);
    end
    cyc(1, 0, 8'h6B);
    checks++;
    if ({ocw2_stb, ocw2_cmd, smm, read_isr, poll_stb} !== {1'b0, 3'b011, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL ocw3_b2b got stb=%b cmd=%b smm=%b risr=%b poll=%b exp 0 011 1 1 0",
               ocw2_stb, ocw2_cmd, smm, read_isr, poll_stb);
    end
    cyc(1, 0, 8'h0C);
    checks++;
    if ({poll_stb, smm, read_isr} !== 3'b111) begin
      failures++; $display("FAIL poll_pulse got poll=%b smm=%b risr=%b exp 1 1 1", poll_stb, smm, read_isr);
    end
    cyc(1, 0, 8'h05);
    checks++;
    if ({poll_stb, ocw2_stb, ocw2_cmd, ocw2_level} !== {1'b0, 1'b1, 3'b000, 3'd5}) begin
      failures++;
      $display("FAIL ocw2_code0 got poll=%b stb=%b cmd=%b lvl=%0d exp 0 1 000 5", poll_stb, ocw2_stb, ocw2_cmd, ocw2_level);
    end
    cyc(0, 0, 8'h00);
    checks++;
    if ({ocw2_stb, poll_stb, ocw2_level} !== {1'b0, 1'b0, 3'd5}) begin
      failures++; $display("FAIL pulse_width got stb=%b poll=%b lvl=%0d exp 0 0 5", ocw2_stb, poll_stb, ocw2_level);
    end
  endtask

  task automatic test_idle_ignored();
    do_reset();
    cyc(1, 1, 8'h55);
    cyc(1, 0, 8'h20);
    checks++;
    if ({imr, ocw2_stb, poll_stb, init_done} !== {IMR_INIT, 3'b000}) begin
      failures++; $display("FAIL idle_ignore got imr=%h stb=%b poll=%b done=%b exp %h 0 0 0",
                           imr, ocw2_stb, poll_stb, init_done, IMR_INIT);
    end
    cyc(1, 1, 8'h48);
    checks++;
    if (vector_base !== 5'h00) begin
      failures++; $display("FAIL idle_no_icw2 got=%h exp=00", vector_base);
    end
  endtask

  task automatic test_restart();
    do_reset();
    cyc(1, 0, 8'h11);
    cyc(1, 1, 8'h48);
    cyc(1, 0, 8'h13);
    checks++;
    if ({init_done, imr, sngl} !== {1'b0, IMR_INIT, 1'b1}) begin
      failures++; $display("FAIL restart_icw1 got done=%b imr=%h sngl=%b exp 0 %h 1", init_done, imr, sngl, IMR_INIT);
    end
    cyc(1, 1, 8'h50);
    cyc(1, 1, 8'h01);
    checks++;
    if ({init_done, upm, cascade_cfg, vector_base} !== {1'b1, 1'b1, 8'h00, 5'h0A}) begin
      failures++; $display("FAIL restart_ready got done=%b upm=%b casc=%h vb=%h exp 1 1 00 0a",
                           init_done, upm, cascade_cfg, vector_base);
    end
    cyc(1, 1, 8'hAA);
    cyc(1, 0, 8'h6B);
    cyc(1, 0, 8'h10);
    checks++;
    if ({init_done, imr, smm, read_isr, upm} !== {1'b0, IMR_INIT, 3'b000}) begin
      failures++; $display("FAIL ready_icw1 got done=%b imr=%h smm=%b risr=%b upm=%b exp 0 %h 0 0 0",
                           init_done, imr, smm, read_isr, upm, IMR_INIT);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(1, 0, 8'h10);
    cyc(1, 1, 8'h48);
    cyc(1, 1, 8'h04);
    cyc(1, 1, 8'hAA);
    cyc(1, 0, 8'h6B);
    cyc(1, 0, 8'h19);
    cyc(1, 1, 8'h48);
    #2 reset = 1;
    #1;
    checks++;
    if (dut_vec !== {28'h0, IMR_INIT, 11'h0}) begin
      failures++; $display("FAIL async_reset got=%h exp=%h", dut_vec, {28'h0, IMR_INIT, 11'h0});
    end
    cyc(1, 0, 8'h10);
    checks++;
    if (dut_vec !== {28'h0, IMR_INIT, 11'h0}) begin
      failures++; $display("FAIL reset_stb_ignored got=%h exp=%h", dut_vec, {28'h0, IMR_INIT, 11'h0});
    end
    reset = 0;
    model_reset();
    cyc(1, 1, 8'h77);
    cyc(0, 0, 8'h00);
    checks++;
    if ({init_done, vector_base, cascade_cfg, imr} !== {1'b0, 5'h00, 8'h00, IMR_INIT}) begin
      failures++; $display("FAIL post_reset_write got done=%b vb=%h casc=%h imr=%h exp 0 00 00 %h",
                           init_done, vector_base, cascade_cfg, imr, IMR_INIT);
    end
  endtask

  task automatic test_random();
    logic       s, a;
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1;
        cyc(0, 0, 8'h00);
        reset = 0;
        model_reset();
      end
      s = ($urandom_range(0, 9) < 7);
      a = $urandom_range(0, 1) == 1;
      d = 8'($urandom());
      if (!a && $urandom_range(0, 7) != 0) d[4] = 1'b0;
      cyc(s, a, d);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL random_cycle%0d got=%h exp=%h", i, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_init();
    test_single_no_icw4();
    test_back_to_back();
    test_idle_ignored();
    test_restart();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
